tstate: RTL
===========

Name: tstate

Overview:
- Instruction timing generator for the 6502 core.
- Produces `sync`, which marks the opcode-fetch cycle. The instruction register latches `data` on the rising edge of `sync`.
- Counts the T-state of the current instruction (T0 is the sync cycle) and terminates the instruction from the decoder's cycle count plus any extra-cycle requests.
- Runs the 7-cycle reset sequence after `rst_n` is released.

Parameters:
- RST_CYCLES, 7, length of the post-reset sequence before the first opcode fetch.
- T_MAX, 7, highest T-state index. Any instruction ends at T_MAX at the latest.

Ports:
- clk  input  1  core clock; all state changes on its rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- rdy  input  1  1 = advance; 0 = freeze all state (stall).
- ncycles  input  3  nominal total cycles of the decoded instruction, including T0. Valid from T1 onward (decoded from the latched opcode).
- extra_cyc  input  1  request one more cycle (page cross / branch taken). Sampled in any cycle where t >= last nominal cycle.
- sync  output  1  1 during the opcode-fetch cycle (T0). Registered.
- t  output  3  current T-state index, 0..T_MAX. Registered.
- last_cycle  output  1  combinational; 1 when this cycle ends the instruction and the next cycle is T0.
- rst_seq  output  1  1 while the reset sequence is running. Registered.

Behaviour:
- Reset (rst_n = 0, asynchronous):
  - sync = 0, t = 0, rst_seq = 1, internal ncyc_q = 2.
  - last_cycle = 0 while rst_seq = 1.
- Reset sequence:
  - With rst_seq = 1 and rdy = 1, t increments each clk: 0, 1, ... RST_CYCLES-1.
  - On the edge after t = RST_CYCLES-1: rst_seq -> 0, sync -> 1, t -> 0.
  - sync stays 0 throughout the sequence.
- State machine: RESET_SEQ -> FETCH (t = 0, sync = 1) -> EXEC (t >= 1, sync = 0) -> FETCH ...
  - FETCH always lasts exactly one rdy-qualified cycle. Its next state is EXEC with t = 1.
- Effective cycle count:
  - ncyc_eff = live ncycles while t = 1; ncyc_q for t >= 2.
  - ncyc_q captures ncycles on the edge leaving t = 1.
  - An ncycles value of 0 or 1 is treated as 2.
- End of instruction, in EXEC: last_cycle = (t >= ncyc_eff-1) & !(extra_cyc & t < T_MAX).
  - last_cycle = 1: next edge sets sync = 1, t = 0.
  - Otherwise: t increments.
- Extra cycles: extra_cyc is honoured in every cycle with t >= ncyc_eff-1, so multiple consecutive extensions are allowed. It is ignored at t = T_MAX, which forces the end of the instruction.
- Stall: rdy = 0 holds sync, t, rst_seq and ncyc_q.
  - last_cycle is still evaluated but has no effect.
  - A stall during T0 keeps sync high, so no second rising edge reaches the IR. The memory system must hold `data` stable.
- sync timing contract: sync rises on the clk edge at which the opcode becomes valid on `data`. `data` must be stable at that edge (IR setup).
- Async reset mid-instruction: outputs go immediately to their reset values without a clock, and the reset sequence restarts from t = 0 on release.
- No combinational path from any input to sync, t or rst_seq.

Decomposition:
- Shared include file holds:
  - localparams T_MAX = 3'd7, RST_CYCLES = 3'd7, MIN_CYCLES = 3'd2;
  - state encodings RESET_SEQ / FETCH / EXEC (2 bits).
- No sub-module: a single FSM plus 3-bit counter and ncyc_q register.
- The decoder that produces ncycles and extra_cyc is a separate, existing-style block and is outside this module.

Test Plan:
- Reset: hold rst_n = 0, release with rdy = 1 -> rst_seq = 1 for 7 clks (t = 0..6, sync = 0), then sync = 1, t = 0, rst_seq = 0.
- ncycles = 2 steady (NOP) -> t alternates 0, 1, 0, 1; sync = 1, 0, 1, 0; last_cycle = 1 at every t = 1.
- ncycles = 4, extra_cyc = 1 only at t = 3 -> t = 0, 1, 2, 3, 4, 0; last_cycle = 1 only at t = 4.
- ncycles = 7, extra_cyc = 1 constantly -> t = 0..7 then 0; last_cycle = 1 at t = 7; ncycles = 1 -> behaves as 2.
- rdy = 0 for 3 clks at t = 2, and separately at t = 0 -> t holds 2 then resumes at 3; sync stays high for 4 clks with a single rising edge.
- Assert rst_n = 0 asynchronously (between clk edges) at t = 3 -> sync = 0, t = 0, rst_seq = 1 immediately; release -> full 7-cycle sequence again.

Source files
------------

// File: rtl/tstate_pkg.sv
// Shared constants, state encoding and cycle-count helper for the 6502 T-state generator.
package tstate_pkg;

  localparam logic [2:0] T_MAX      = 3'd7;
  localparam logic [2:0] RST_CYCLES = 3'd7;
  localparam logic [2:0] MIN_CYCLES = 3'd2;

  typedef enum logic [1:0] {
    RESET_SEQ = 2'd0,
    FETCH     = 2'd1,
    EXEC      = 2'd2
  } state_t;

  // Decoder counts below two are meaningless: every instruction has at least T0 and T1.
  function automatic logic [2:0] clamp_cycles(input logic [2:0] n);
    return (n < MIN_CYCLES) ? MIN_CYCLES : n;
  endfunction

endpackage

// File: rtl/tstate.sv
// 6502 instruction timing: reset sequence, sync (T0) generation and T-state counting.
// All state registered; rdy = 0 freezes every register, last_cycle is the only combinational output.
module tstate (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rdy,
  input  logic [2:0] ncycles,
  input  logic       extra_cyc,
  output logic       sync,
  output logic [2:0] t,
  output logic       last_cycle,
  output logic       rst_seq
);
  import tstate_pkg::*;

  state_t     state;
  logic [2:0] ncyc_q;
  logic [2:0] ncyc_live;
  logic [2:0] ncyc_eff;

  // ncycles is only decoded once the opcode is latched, so T1 uses it live and later cycles use the copy.
  always_comb begin
    ncyc_live  = clamp_cycles(ncycles);
    ncyc_eff   = (t == 3'd1) ? ncyc_live : ncyc_q;
    last_cycle = (state == EXEC) && (t >= ncyc_eff - 3'd1) &&
                 !(extra_cyc && (t < T_MAX));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RESET_SEQ;
      sync    <= 1'b0;
      t       <= 3'd0;
      rst_seq <= 1'b1;
      ncyc_q  <= MIN_CYCLES;
    end else if (rdy) begin
      case (state)
        RESET_SEQ: begin
          if (t == RST_CYCLES - 3'd1) begin
            state   <= FETCH;
            sync    <= 1'b1;
            t       <= 3'd0;
            rst_seq <= 1'b0;
          end else begin
            t <= t + 3'd1;
          end
        end
        FETCH: begin
          state <= EXEC;
          sync  <= 1'b0;
          t     <= 3'd1;
        end
        EXEC: begin
          if (t == 3'd1) ncyc_q <= ncyc_live;
          if (last_cycle) begin
            state <= FETCH;
            sync  <= 1'b1;
            t     <= 3'd0;
          end else begin
            t <= t + 3'd1;
          end
        end
        default: begin
          state   <= RESET_SEQ;
          sync    <= 1'b0;
          t       <= 3'd0;
          rst_seq <= 1'b1;
        end
      endcase
    end
  end

endmodule
